mem_access_unit: RTL and testbench

MEM-stage consumer of the EXE/MEM pipeline register outputs. It decodes the latched control and address, then runs a req/ack transaction sequence on a 32-bit data-memory bus. Byte, word and double (two-beat) accesses are supported. The unit stalls the upstream pipeline while an access is in flight and loads the MEM/WB outputs when the instruction retires.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_lane_align.sv | 36 +++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage access unit: FSM state codes,
// access-size encoding and the alignment rule.
package mem_pkg;

  localparam int BEAT_BYTES = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BEAT0 = 2'd1;
  localparam state_t ST_BEAT1 = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_WORD   = 2'd1,
    SZ_DOUBLE = 2'd2
  } size_t;

  // Byte takes priority if both size flags are set by the decoder.
  function automatic size_t decode_size(input logic byte_op, input logic dbl_op);
    if (byte_op)     return SZ_BYTE;
    else if (dbl_op) return SZ_DOUBLE;
    else             return SZ_WORD;
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [2:0] lo);
    case (sz)
      SZ_BYTE:   return 1'b1;
      SZ_WORD:   return (lo[1:0] == 2'b00);
      SZ_DOUBLE: return (lo == 3'b000);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Req/ack data-memory bus between the MEM-stage unit (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and write data for a beat,
// plus read-lane extraction with sign extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  byte_off,
  input  logic        upper_beat,
  input  logic [63:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [63:0] load_data
);

  logic [7:0] rd_lane;

  always_comb begin
    be        = 4'hF;
    wdata     = store_data[31:0];
    rd_lane   = rdata[{byte_off, 3'b000} +: 8];
    load_data = {{32{rdata[31]}}, rdata};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << byte_off;
        wdata     = {4{store_data[7:0]}};
        load_data = {{56{rd_lane[7]}}, rd_lane};
      end
      SZ_DOUBLE: begin
        wdata = upper_beat ? store_data[63:32] : store_data[31:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage unit: decodes the EXE/MEM register, runs one or two req/ack beats
// on the data bus, stalls upstream while busy and loads MEM/WB on retire.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] EXE_MEM_Result,
  input  logic [63:0] EXE_MEM_Treg,
  input  logic [4:0]  EXE_MEM_DstReg,
  input  logic        EXE_MEM_MemRead,
  input  logic        EXE_MEM_MemWrite,
  input  logic        EXE_MEM_MemtoReg,
  input  logic        EXE_MEM_RegWrite,
  input  logic        EXE_MEM_Byte,
  input  logic        EXE_MEM_double,
  mem_access_unit_if.master bus,
  output logic        MEM_Stall,
  output logic        MEM_AlignErr,
  output logic [63:0] MEM_WB_Data,
  output logic [4:0]  MEM_WB_DstReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg
);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [63:0]       buf_q, buf_d;
  logic              align_err_q, align_err_d;
  logic [63:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_dst_q, wb_dst_d;
  logic              wb_rw_q, wb_rw_d;
  logic              wb_m2r_q, wb_m2r_d;
  logic              stall;

  logic              memop;
  logic              aligned;
  size_t             size;
  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [63:0]       lane_load;

  assign memop     = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign size      = decode_size(EXE_MEM_Byte, EXE_MEM_double);
  assign byte_addr = EXE_MEM_Result[ADDR_W-1:0];
  assign word_addr = {byte_addr[ADDR_W-1:2], 2'b00};
  assign aligned   = is_aligned(size, byte_addr[2:0]);

  // In BEAT0 the lane unit prepares the upper half for a following double beat.
  mem_lane_align u_lane (
    .size       (size),
    .byte_off   (byte_addr[1:0]),
    .upper_beat (state_q == ST_BEAT0),
    .store_data (EXE_MEM_Treg),
    .rdata      (bus.mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    buf_d       = buf_q;
    align_err_d = 1'b0;
    wb_data_d   = wb_data_q;
    wb_dst_d    = wb_dst_q;
    wb_rw_d     = wb_rw_q;
    wb_m2r_d    = wb_m2r_q;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (memop && aligned) begin
          stall   = 1'b1;
          state_d = ST_BEAT0;
          req_d   = 1'b1;
          we_d    = EXE_MEM_MemWrite;
          addr_d  = word_addr;
          wdata_d = lane_wdata;
          be_d    = lane_be;
        end else if (memop) begin
          align_err_d = 1'b1;
          wb_data_d   = '0;
          wb_dst_d    = '0;
          wb_rw_d     = 1'b0;
          wb_m2r_d    = 1'b0;
        end else begin
          wb_data_d = EXE_MEM_Result;
          wb_dst_d  = EXE_MEM_DstReg;
          wb_rw_d   = EXE_MEM_RegWrite;
          wb_m2r_d  = EXE_MEM_MemtoReg;
        end
      end

      ST_BEAT0: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          if (size == SZ_DOUBLE) begin
            state_d = ST_BEAT1;
            addr_d  = word_addr + ADDR_W'(BEAT_BYTES);
            wdata_d = lane_wdata;
            be_d    = lane_be;
            buf_d   = {buf_q[63:32], bus.mem_rdata};
          end else begin
            state_d = ST_DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            buf_d   = lane_load;
          end
        end
      end

      ST_BEAT1: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          buf_d   = {bus.mem_rdata, buf_q[31:0]};
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        wb_data_d = (EXE_MEM_MemRead && !EXE_MEM_MemWrite) ? buf_q : EXE_MEM_Result;
        wb_dst_d  = EXE_MEM_DstReg;
        wb_rw_d   = EXE_MEM_RegWrite;
        wb_m2r_d  = EXE_MEM_MemtoReg;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      buf_q       <= '0;
      align_err_q <= 1'b0;
      wb_data_q   <= '0;
      wb_dst_q    <= '0;
      wb_rw_q     <= 1'b0;
      wb_m2r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      buf_q       <= buf_d;
      align_err_q <= align_err_d;
      wb_data_q   <= wb_data_d;
      wb_dst_q    <= wb_dst_d;
      wb_rw_q     <= wb_rw_d;
      wb_m2r_q    <= wb_m2r_d;
    end
  end

  // Stall is combinational, so it must also be forced low while reset is held.
  assign MEM_Stall       = stall & rst_n;
  assign MEM_AlignErr    = align_err_q;
  assign MEM_WB_Data     = wb_data_q;
  assign MEM_WB_DstReg   = wb_dst_q;
  assign MEM_WB_RegWrite = wb_rw_q;
  assign MEM_WB_MemtoReg = wb_m2r_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with a procedural memory responder.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] exe_result;
  logic [63:0] exe_treg;
  logic [4:0]  exe_dst;
  logic        exe_rd, exe_wr, exe_m2r, exe_rw, exe_byte, exe_dbl;
  logic        mem_stall, mem_align_err;
  logic [63:0] wb_data;
  logic [4:0]  wb_dst;
  logic        wb_rw, wb_m2r;

  int pass_cnt  = 0;
  int check_cnt = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .BUS_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .EXE_MEM_Result   (exe_result),
    .EXE_MEM_Treg     (exe_treg),
    .EXE_MEM_DstReg   (exe_dst),
    .EXE_MEM_MemRead  (exe_rd),
    .EXE_MEM_MemWrite (exe_wr),
    .EXE_MEM_MemtoReg (exe_m2r),
    .EXE_MEM_RegWrite (exe_rw),
    .EXE_MEM_Byte     (exe_byte),
    .EXE_MEM_double   (exe_dbl),
    .bus              (bus),
    .MEM_Stall        (mem_stall),
    .MEM_AlignErr     (mem_align_err),
    .MEM_WB_Data      (wb_data),
    .MEM_WB_DstReg    (wb_dst),
    .MEM_WB_RegWrite  (wb_rw),
    .MEM_WB_MemtoReg  (wb_m2r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [63:0] result;
    logic [63:0] treg;
    logic [4:0]  dst;
    logic        rd, wr, m2r, rw, byt, dbl;
    int          waits;
    logic [63:0] rdata;
    logic [63:0] exp_data;
    logic [31:0] exp_addr0, exp_wdata0, exp_addr1, exp_wdata1;
    logic [3:0]  exp_be;
    logic        exp_err, exp_rw;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    exe_result = v.result;
    exe_treg   = v.treg;
    exe_dst    = v.dst;
    exe_rd     = v.rd;
    exe_wr     = v.wr;
    exe_m2r    = v.m2r;
    exe_rw     = v.rw;
    exe_byte   = v.byt;
    exe_dbl    = v.dbl;
  endtask

  task automatic apply_nop();
    exe_result = '0; exe_treg = '0; exe_dst = '0;
    exe_rd = 0; exe_wr = 0; exe_m2r = 0; exe_rw = 0; exe_byte = 0; exe_dbl = 0;
  endtask

  task automatic run_vector(input vec_t v);
    logic [31:0] got_addr[2];
    logic [31:0] got_wdata[2];
    logic [3:0]  got_be[2];
    logic        got_we[2];
    int beat, wcnt, stalls;
    bit started, done, hold_err;
    applyStimulus(v);
    #1;
    checkOutput({v.name, "_stall_issue"}, 64'(mem_stall), 64'((v.rd | v.wr) && !v.exp_err));
    if (!(v.rd | v.wr)) begin
      @(posedge clk); #1;
      checkOutput({v.name, "_wb_data"}, wb_data, v.exp_data);
      checkOutput({v.name, "_wb_dst"}, 64'(wb_dst), 64'(v.dst));
      checkOutput({v.name, "_wb_rw"}, 64'(wb_rw), 64'(v.exp_rw));
    end else if (v.exp_err) begin
      @(posedge clk); #1;
      checkOutput({v.name, "_align_err"}, 64'(mem_align_err), 64'd1);
      checkOutput({v.name, "_no_req"}, 64'(bus.mem_req), 64'd0);
      checkOutput({v.name, "_bubble_rw"}, 64'(wb_rw), 64'd0);
      checkOutput({v.name, "_bubble_data"}, wb_data, 64'd0);
      apply_nop();
      @(posedge clk); #1;
      checkOutput({v.name, "_err_pulse_end"}, 64'(mem_align_err), 64'd0);
    end else begin
      beat = 0; wcnt = 0; stalls = 0; started = 0; done = 0; hold_err = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
          if (mem_stall) stalls++;
          if (!started && beat < 2) begin
            got_addr[beat]  = bus.mem_addr;
            got_wdata[beat] = bus.mem_wdata;
            got_be[beat]    = bus.mem_be;
            got_we[beat]    = bus.mem_we;
            started = 1;
            wcnt = v.waits;
          end else if (beat < 2 && (bus.mem_addr !== got_addr[beat] || bus.mem_be !== got_be[beat]
                                    || bus.mem_wdata !== got_wdata[beat])) begin
            hold_err = 1;
          end
          if (wcnt == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = (beat == 0) ? v.rdata[31:0] : v.rdata[63:32];
            started = 0;
            beat++;
          end else begin
            wcnt--;
          end
        end else begin
          done = 1;
          checkOutput({v.name, "_stall_done"}, 64'(mem_stall), 64'd0);
        end
      end
      if (!done) checkOutput({v.name, "_timeout"}, 64'd0, 64'd1);
      checkOutput({v.name, "_beats"}, 64'(beat), v.dbl ? 64'd2 : 64'd1);
      checkOutput({v.name, "_stall_cycles"}, 64'(stalls), 64'((v.dbl ? 2 : 1) * (v.waits + 1)));
      checkOutput({v.name, "_hold"}, 64'(hold_err), 64'd0);
      checkOutput({v.name, "_addr0"}, 64'(got_addr[0]), 64'(v.exp_addr0));
      checkOutput({v.name, "_be0"}, 64'(got_be[0]), 64'(v.exp_be));
      checkOutput({v.name, "_we0"}, 64'(got_we[0]), 64'(v.wr));
      if (v.wr) checkOutput({v.name, "_wdata0"}, 64'(got_wdata[0]), 64'(v.exp_wdata0));
      if (v.dbl && beat == 2) begin
        checkOutput({v.name, "_addr1"}, 64'(got_addr[1]), 64'(v.exp_addr1));
        checkOutput({v.name, "_be1"}, 64'(got_be[1]), 64'hF);
        if (v.wr) checkOutput({v.name, "_wdata1"}, 64'(got_wdata[1]), 64'(v.exp_wdata1));
      end
      @(posedge clk); #1;
      checkOutput({v.name, "_wb_data"}, wb_data, v.exp_data);
      checkOutput({v.name, "_wb_dst"}, 64'(wb_dst), 64'(v.dst));
      checkOutput({v.name, "_wb_rw"}, 64'(wb_rw), 64'(v.exp_rw));
      checkOutput({v.name, "_wb_m2r"}, 64'(wb_m2r), 64'(v.m2r));
      checkOutput({v.name, "_idle_req"}, 64'(bus.mem_req), 64'd0);
      apply_nop();
    end
  endtask

  initial begin
    vec_t reload;
    //        name               result          treg                    dst rd wr m2r rw byt dbl waits rdata                   exp_data                 addr0      wdata0        addr1      wdata1        be    err rw
    vecs[0]  = '{"alu",           64'h1234, 64'h0,                  5,  0, 0, 0, 1, 0, 0, 0, 64'h0,                  64'h1234,                32'h0,     32'h0,        32'h0,     32'h0,        4'h0, 0, 1};
    vecs[1]  = '{"ld_word_wait",  64'h100,  64'h0,                  7,  1, 0, 1, 1, 0, 0, 2, 64'h8000_0001,          64'hFFFF_FFFF_8000_0001, 32'h100,   32'h0,        32'h0,     32'h0,        4'hF, 0, 1};
    vecs[2]  = '{"st_double",     64'h208,  64'hAABBCCDD_11223344,  0,  0, 1, 0, 0, 0, 1, 0, 64'h0,                  64'h208,                 32'h208,   32'h11223344, 32'h20C,   32'hAABBCCDD, 4'hF, 0, 0};
    vecs[3]  = '{"ld_byte_pos",   64'h103,  64'h0,                  3,  1, 0, 1, 1, 1, 0, 0, 64'h7F00_0000,          64'h7F,                  32'h100,   32'h0,        32'h0,     32'h0,        4'h8, 0, 1};
    vecs[4]  = '{"ld_byte_neg",   64'h103,  64'h0,                  3,  1, 0, 1, 1, 1, 0, 0, 64'h8000_0000,          64'hFFFF_FFFF_FFFF_FF80, 32'h100,   32'h0,        32'h0,     32'h0,        4'h8, 0, 1};
    vecs[5]  = '{"ld_word_misal", 64'h102,  64'h0,                  9,  1, 0, 1, 1, 0, 0, 0, 64'h0,                  64'h0,                   32'h0,     32'h0,        32'h0,     32'h0,        4'h0, 1, 0};
    vecs[6]  = '{"st_byte",       64'h101,  64'h5A,                 0,  0, 1, 0, 0, 1, 0, 1, 64'h0,                  64'h101,                 32'h100,   32'h5A5A5A5A, 32'h0,     32'h0,        4'h2, 0, 0};
    vecs[7]  = '{"ld_double",     64'h300,  64'h0,                  12, 1, 0, 1, 1, 0, 1, 1, 64'h82345678_11111111,  64'h82345678_11111111,  32'h300,   32'h0,        32'h304,   32'h0,        4'hF, 0, 1};
    vecs[8]  = '{"st_word",       64'h40,   64'hDEADBEEF_CAFEF00D,  0,  0, 1, 0, 0, 0, 0, 0, 64'h0,                  64'h40,                  32'h40,    32'hCAFEF00D, 32'h0,     32'h0,        4'hF, 0, 0};
    vecs[9]  = '{"ld_dbl_misal",  64'h304,  64'h0,                  4,  1, 0, 1, 1, 0, 1, 0, 64'h0,                  64'h0,                   32'h0,     32'h0,        32'h0,     32'h0,        4'h0, 1, 0};
    vecs[10] = '{"ld_byte_lane2", 64'h102,  64'h0,                  6,  1, 0, 1, 1, 1, 0, 0, 64'h00AB_0000,          64'hFFFF_FFFF_FFFF_FFAB, 32'h100,   32'h0,        32'h0,     32'h0,        4'h4, 0, 1};
    vecs[11] = '{"rd_wr_both",    64'h50,   64'h1,                  8,  1, 1, 1, 1, 0, 0, 0, 64'hFFFF_FFFF,          64'h50,                  32'h50,    32'h1,        32'h0,     32'h0,        4'hF, 0, 1};

    apply_nop();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_req", 64'(bus.mem_req), 64'd0);
    checkOutput("reset_stall", 64'(mem_stall), 64'd0);
    checkOutput("reset_wb_data", wb_data, 64'd0);
    checkOutput("reset_align", 64'(mem_align_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vector(vecs[i]);

    // Stray ack while idle must not start anything.
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checkOutput("stray_ack_req", 64'(bus.mem_req), 64'd0);
    checkOutput("stray_ack_stall", 64'(mem_stall), 64'd0);

    // Reset asserted during BEAT1 of a double load.
    reload = vecs[7];
    reload.result = 64'h400;
    reload.dst    = 10;
    applyStimulus(reload);
    @(posedge clk); #1;
    checkOutput("rst_seq_beat0_req", 64'(bus.mem_req), 64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checkOutput("rst_seq_beat1_req", 64'(bus.mem_req), 64'd1);
    checkOutput("rst_seq_beat1_addr", 64'(bus.mem_addr), 64'h404);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req", 64'(bus.mem_req), 64'd0);
    checkOutput("rst_mid_stall", 64'(mem_stall), 64'd0);
    checkOutput("rst_mid_wb_data", wb_data, 64'd0);
    checkOutput("rst_mid_wb_rw", 64'(wb_rw), 64'd0);
    checkOutput("rst_mid_wb_dst", 64'(wb_dst), 64'd0);
    apply_nop();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    reload = vecs[1];
    reload.name   = "post_rst_ld";
    reload.result = 64'h500;
    reload.waits  = 0;
    reload.rdata  = 64'h1234_5678;
    reload.exp_data  = 64'h1234_5678;
    reload.exp_addr0 = 32'h500;
    run_vector(reload);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
